// File: rtl/camera_capture.sv
// OV7670 capture stage: synchronises the camera bus into CLK, packs RGB565 byte pairs
// into RGB332 and drives the frame-buffer write port with frame completion/error pulses.
module camera_capture #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_WIDTH    = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CAM_PCLK,
  input  logic                  CAM_HREF,
  input  logic                  CAM_VSYNC,
  input  logic [7:0]            CAM_DATA,
  output logic [7:0]            PIXEL_OUT,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic                  W_EN,
  output logic                  FRAME_DONE,
  output logic                  FRAME_ERR
);

  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0]         X_LIM     = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0]         Y_LIM     = YW'(SCREEN_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(SCREEN_WIDTH);

  localparam logic [0:0] WAIT_SYNC = 1'b0;
  localparam logic [0:0] ACTIVE    = 1'b1;

  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       href_s1_q, href_s2_q, href_s3_q;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic [7:0] data_s1_q, data_s2_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pclk_s1_q <= 1'b0; pclk_s2_q <= 1'b0; pclk_s3_q <= 1'b0;
      href_s1_q <= 1'b0; href_s2_q <= 1'b0; href_s3_q <= 1'b0;
      vs_s1_q   <= 1'b0; vs_s2_q   <= 1'b0; vs_s3_q   <= 1'b0;
      data_s1_q <= '0;   data_s2_q <= '0;
    end else begin
      pclk_s1_q <= CAM_PCLK;  pclk_s2_q <= pclk_s1_q; pclk_s3_q <= pclk_s2_q;
      href_s1_q <= CAM_HREF;  href_s2_q <= href_s1_q; href_s3_q <= href_s2_q;
      vs_s1_q   <= CAM_VSYNC; vs_s2_q   <= vs_s1_q;   vs_s3_q   <= vs_s2_q;
      data_s1_q <= CAM_DATA;  data_s2_q <= data_s1_q;
    end
  end

  // Event stage: registering the detected edges gives the three-cycle PCLK-to-W_EN latency.
  logic       byte_vld_d, href_fall_d, vs_fall_d, vs_rise_d;
  logic       byte_vld_q, href_fall_q, vs_fall_q, vs_rise_q;
  logic [7:0] byte_d, byte_q;

  always_comb begin
    byte_vld_d  = pclk_s2_q & ~pclk_s3_q & href_s2_q;
    href_fall_d = ~href_s2_q & href_s3_q;
    vs_fall_d   = ~vs_s2_q & vs_s3_q;
    vs_rise_d   = vs_s2_q & ~vs_s3_q;
    byte_d      = data_s2_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      byte_vld_q  <= 1'b0;
      href_fall_q <= 1'b0;
      vs_fall_q   <= 1'b0;
      vs_rise_q   <= 1'b0;
      byte_q      <= '0;
    end else begin
      byte_vld_q  <= byte_vld_d;
      href_fall_q <= href_fall_d;
      vs_fall_q   <= vs_fall_d;
      vs_rise_q   <= vs_rise_d;
      byte_q      <= byte_d;
    end
  end

  logic [0:0]            state_d, state_q;
  logic [XW-1:0]         x_d, x_q;
  logic [YW-1:0]         y_d, y_q;
  logic                  phase_d, phase_q;
  logic [5:0]            hi_d, hi_q;
  logic                  err_d, err_q;
  logic                  drop_d, drop_q;
  logic [ADDR_WIDTH-1:0] addr_next_d, addr_next_q;
  logic [ADDR_WIDTH-1:0] line_base_d, line_base_q;
  logic [7:0]            pixel_d, pixel_q;
  logic [ADDR_WIDTH-1:0] w_addr_d, w_addr_q;
  logic                  w_en_d, w_en_q;
  logic                  done_pend_d, done_pend_q;
  logic                  done_err_d, done_err_q;
  logic                  frame_done_d, frame_done_q;
  logic                  frame_err_d, frame_err_q;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    err_d        = err_q;
    drop_d       = drop_q;
    addr_next_d  = addr_next_q;
    line_base_d  = line_base_q;
    pixel_d      = pixel_q;
    w_addr_d     = w_addr_q;
    w_en_d       = 1'b0;
    done_pend_d  = 1'b0;
    done_err_d   = done_err_q;
    frame_done_d = done_pend_q;
    frame_err_d  = done_pend_q & done_err_q;
    case (state_q)
      WAIT_SYNC: begin
        if (vs_fall_q) begin
          state_d     = ACTIVE;
          x_d         = '0;
          y_d         = '0;
          phase_d     = 1'b0;
          err_d       = 1'b0;
          drop_d      = 1'b0;
          addr_next_d = '0;
          line_base_d = '0;
        end
      end
      ACTIVE: begin
        if (byte_vld_q) begin
          if (!phase_q) begin
            hi_d    = {byte_q[7:5], byte_q[2:0]};
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((x_q < X_LIM) && (y_q < Y_LIM)) begin
              w_en_d      = 1'b1;
              pixel_d     = {hi_q, byte_q[4:3]};
              w_addr_d    = addr_next_q;
              addr_next_d = addr_next_q + ADDR_WIDTH'(1);
              x_d         = x_q + XW'(1);
            end else begin
              err_d  = 1'b1;
              drop_d = 1'b1;
            end
          end
        end else if (href_fall_q) begin
          if ((x_q != '0) || drop_q) begin
            if (y_q < Y_LIM) begin
              y_d         = y_q + YW'(1);
              line_base_d = line_base_q + LINE_STEP;
              addr_next_d = line_base_q + LINE_STEP;
            end
            if (x_q != X_LIM) err_d = 1'b1;
          end
          // An orphan byte is dropped even on an otherwise empty line so pairing restarts cleanly.
          if (phase_q) err_d = 1'b1;
          x_d     = '0;
          phase_d = 1'b0;
          drop_d  = 1'b0;
        end
        // FRAME_DONE is deferred one cycle so a write issued here always precedes it.
        if (vs_rise_q) begin
          state_d     = WAIT_SYNC;
          done_pend_d = 1'b1;
          done_err_d  = err_d | (y_d != Y_LIM);
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= WAIT_SYNC;
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
      addr_next_q  <= '0;
      line_base_q  <= '0;
      pixel_q      <= '0;
      w_addr_q     <= '0;
      w_en_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      done_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
      addr_next_q  <= addr_next_d;
      line_base_q  <= line_base_d;
      pixel_q      <= pixel_d;
      w_addr_q     <= w_addr_d;
      w_en_q       <= w_en_d;
      done_pend_q  <= done_pend_d;
      done_err_q   <= done_err_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign PIXEL_OUT  = pixel_q;
  assign W_ADDR     = w_addr_q;
  assign W_EN       = w_en_q;
  assign FRAME_DONE = frame_done_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench for camera_capture on a reduced 16x6 geometry: stimulus pushes
// expected writes/frame results, a negedge monitor pops and compares them.
module tb_camera_capture;

  localparam int W  = 16;
  localparam int H  = 6;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          pclk, href, vsync;
  logic [7:0]    data;
  logic [7:0]    pixel_out;
  logic [AW-1:0] w_addr;
  logic          w_en, frame_done, frame_err;

  camera_capture #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .ADDR_WIDTH   (AW)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .CAM_PCLK  (pclk),
    .CAM_HREF  (href),
    .CAM_VSYNC (vsync),
    .CAM_DATA  (data),
    .PIXEL_OUT (pixel_out),
    .W_ADDR    (w_addr),
    .W_EN      (w_en),
    .FRAME_DONE(frame_done),
    .FRAME_ERR (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    pix;
    int            cyc;
  } wr_t;

  wr_t  wq[$];
  logic fq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the capture geometry
  int       mx, my;
  bit       mph, merr, mdrop, mact;
  logic [7:0] mhi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  wr_t  mon_e;
  logic mon_f;
  always @(negedge clk) begin
    if (w_en) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: W_ADDR=%0d PIXEL_OUT=0x%0h, expected no write (t=%0t)",
                 w_addr, pixel_out, $time);
      end else begin
        mon_e = wq.pop_front();
        check("w_addr", 32'(w_addr), 32'(mon_e.addr));
        check("pixel_out", 32'(pixel_out), 32'(mon_e.pix));
        check("w_en_latency_cycle", cyc, mon_e.cyc);
      end
    end
    if (frame_done) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: FRAME_DONE=1, expected 0 (t=%0t)", $time);
      end else begin
        mon_f = fq.pop_front();
        check("frame_err", 32'(frame_err), 32'(mon_f));
      end
    end else if (frame_err) begin
      checks++;
      errors++;
      $display("FAIL frame_err_without_done: FRAME_ERR=1, expected 0 (t=%0t)", $time);
    end
  end

  // One camera byte; hand=1 substitutes a hand-computed pixel for the model's.
  task automatic cam_byte(input logic [7:0] d, input bit hand, input logic [7:0] hand_pix);
    wr_t t;
    @(negedge clk);
    data = d;
    href = 1'b1;
    pclk = 1'b0;
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    if (mact) begin
      if (!mph) begin
        mhi = d;
        mph = 1'b1;
      end else begin
        mph = 1'b0;
        if (mx < W && my < H) begin
          t.addr = AW'(my * W + mx);
          t.pix  = hand ? hand_pix : {mhi[7:5], mhi[2:0], d[4:3]};
          t.cyc  = cyc + 4;
          wq.push_back(t);
          mx++;
        end else begin
          merr  = 1'b1;
          mdrop = 1'b1;
        end
      end
    end
    repeat (2) @(negedge clk);
    pclk = 1'b0;
  endtask

  task automatic line_end();
    repeat (2) @(negedge clk);
    href = 1'b0;
    if (mact) begin
      if (mx != 0 || mdrop) begin
        if (my < H) my++;
        if (mx != W) merr = 1'b1;
      end
      if (mph) merr = 1'b1;
      mx    = 0;
      mph   = 1'b0;
      mdrop = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic send_bytes(input int n, input int seed);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(seed * 37 + i * 11 + 5);
      cam_byte(b, 1'b0, 8'h00);
    end
  endtask

  task automatic send_line(input int n, input int seed);
    send_bytes(n, seed);
    line_end();
  endtask

  task automatic vs_fall();
    @(negedge clk);
    vsync = 1'b0;
    mact  = 1'b1;
    mx    = 0;
    my    = 0;
    mph   = 1'b0;
    merr  = 1'b0;
    mdrop = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic vs_rise();
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    if (mact) fq.push_back(merr || (my != H));
    mact = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pixel_out"}, 32'(pixel_out), 32'h0);
    check({tag, "_w_addr"}, 32'(w_addr), 32'h0);
    check({tag, "_w_en"}, 32'(w_en), 32'h0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    mact = 1'b0; mx = 0; my = 0; mph = 1'b0; merr = 1'b0; mdrop = 1'b0; mhi = '0;
    rst = 1'b1; pclk = 1'b0; href = 1'b0; vsync = 1'b1; data = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Bytes before the first VSYNC fall are ignored
    send_line(10, 1);

    // Colour packing plus a nominal clean frame
    vs_fall();
    cam_byte(8'hF8, 1'b0, 8'h00); cam_byte(8'h1F, 1'b1, 8'hE3);
    cam_byte(8'h07, 1'b0, 8'h00); cam_byte(8'hE0, 1'b1, 8'h1C);
    cam_byte(8'hFF, 1'b0, 8'h00); cam_byte(8'hFF, 1'b1, 8'hFF);
    send_line(2 * W - 6, 2);
    for (int l = 1; l < H; l++) send_line(2 * W, l + 10);
    vs_rise();

    // Long line: extra pixels dropped, following line still starts at (y+1)*W
    vs_fall();
    send_line(2 * W, 20);
    send_line(2 * W + 4, 21);
    for (int l = 2; l < H; l++) send_line(2 * W, l + 20);
    vs_rise();

    // Orphan byte on a short line and one line missing from the frame
    vs_fall();
    send_line(2 * W - 1, 30);
    for (int l = 1; l < H - 1; l++) send_line(2 * W, l + 30);
    vs_rise();

    // Reset mid-frame, junk bytes until the next sync, then a clean frame from address 0
    vs_fall();
    for (int l = 0; l < 3; l++) send_line(2 * W, l + 40);
    send_bytes(4, 44);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_frame_reset");
    mact = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_line(6, 45);
    send_line(2 * W, 46);
    vs_rise();
    vs_fall();
    for (int l = 0; l < H; l++) send_line(2 * W, l + 50);
    vs_rise();

    repeat (30) @(negedge clk);
    check("pending_writes_left", wq.size(), 0);
    check("pending_frames_left", fq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
